ripple_count_monitor: RTL and testbench

- Downstream consumer of the 3-bit transmission-gate ripple counter outputs (T0, T1, T2).
- Samples the counter asynchronously to Clk and filters ripple glitches to produce a validated count.
- Decodes the validated count to one-hot, checks that each change is a +1 step, and counts wrap-arounds.
- Result feeds the sequencing/control logic that consumes counter phase.

---
 rtl/ripple_count_monitor.sv | 190 +++++++++++++++++++
 tb/tb_ripple_count_monitor.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor
//   Consumes the three outputs of a free-running ripple counter that runs
//   asynchronously to Clk. It produces a validated count free of ripple
//   glitches, a one-hot phase decode, step/wrap/skip pulses, and a wrap
//   counter with a sticky overflow flag.
//
// Ports
//   Clk      in   sampling clock; all state changes on the rising edge
//   nRst     in   asynchronous active-low reset
//   T0..T2   in   counter bits (T0 = LSB), asynchronous to Clk
//   Clr      in   synchronous clear of WrapCnt, Err and Ovf
//   Q        out  validated count {T2,T1,T0}
//   Valid    out  high once the first value has been accepted after reset
//   Phase    out  one-hot decode of Q while Valid, otherwise zero
//   Step     out  one-cycle pulse on a +1 (mod 8) change of Q
//   Wrap     out  one-cycle pulse on a 7->0 change of Q (Step is also high)
//   Skip     out  one-cycle pulse on any other change of Q
//   Err      out  sticky, set by Skip
//   WrapCnt  out  number of wraps modulo 2^WRAP_W
//   Ovf      out  sticky, set when WrapCnt rolls over to zero
module ripple_count_monitor #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_SAMPLES = 2,
  parameter int WRAP_W         = 8
) (
  input  logic              Clk,
  input  logic              nRst,
  input  logic              T0,
  input  logic              T1,
  input  logic              T2,
  input  logic              Clr,
  output logic [2:0]        Q,
  output logic              Valid,
  output logic [7:0]        Phase,
  output logic              Step,
  output logic              Wrap,
  output logic              Skip,
  output logic              Err,
  output logic [WRAP_W-1:0] WrapCnt,
  output logic              Ovf
);

  localparam int                CNT_W    = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_SAMPLES - 1);
  localparam int                FILL_W   = $clog2(SYNC_STAGES + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_STAGES);

  logic [2:0] t_raw;
  logic [2:0] s_val;

  assign t_raw = {T2, T1, T0};

  // Per-bit synchronizer chains; the last stage of each chain is S.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_q;
      logic [SYNC_STAGES-1:0] chain_d;

      always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], t_raw[gi]};
      end

      always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) chain_q <= '0;
        else       chain_q <= chain_d;
      end

      assign s_val[gi] = chain_q[SYNC_STAGES-1];
    end
  endgenerate

  logic [FILL_W-1:0] fill_q, fill_d;
  logic [2:0]        c_q, c_d;
  logic              c_real_q, c_real_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        q_q, q_d;
  logic              valid_q, valid_d;
  logic              step_q, step_d;
  logic              wrap_q, wrap_d;
  logic              skip_q, skip_d;
  logic              err_q, err_d;
  logic [WRAP_W-1:0] wcnt_q, wcnt_d;
  logic              ovf_q, ovf_d;

  logic              s_real;
  logic              accept;
  logic [2:0]        q_plus1;

  always_comb begin
    fill_d   = fill_q;
    c_d      = c_q;
    c_real_d = c_real_q;
    cnt_d    = cnt_q;
    q_d      = q_q;
    valid_d  = valid_q;
    step_d   = 1'b0;
    wrap_d   = 1'b0;
    skip_d   = 1'b0;
    err_d    = err_q;
    wcnt_d   = wcnt_q;
    ovf_d    = ovf_q;
    accept   = 1'b0;
    q_plus1  = q_q + 3'd1;

    // The zeros left in the synchronizer by reset are not real samples.
    // S only carries a genuine sample once the chain has been filled, and
    // C only counts as genuine once it has been loaded from such an S, so
    // a reset-matching input value still sees the full acceptance latency.
    s_real = (fill_q == FILL_MAX);
    if (!s_real) fill_d = fill_q + FILL_W'(1);

    if (!c_real_q || (s_val != c_q)) begin
      c_d      = s_val;
      cnt_d    = '0;
      c_real_d = s_real;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!valid_q || (c_q != q_q)) begin
      accept = 1'b1;
    end

    if (accept) begin
      q_d     = c_q;
      valid_d = 1'b1;
      // The first value after reset is only adopted, never judged.
      if (valid_q) begin
        if (c_q == q_plus1) begin
          step_d = 1'b1;
          if (q_q == 3'd7) begin
            wrap_d = 1'b1;
            wcnt_d = wcnt_q + WRAP_W'(1);
            if (&wcnt_q) ovf_d = 1'b1;
          end
        end else begin
          skip_d = 1'b1;
          err_d  = 1'b1;
        end
      end
    end

    // Clear overrides any simultaneous count/flag update; pulses still go out.
    if (Clr) begin
      wcnt_d = '0;
      err_d  = 1'b0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      fill_q   <= '0;
      c_q      <= '0;
      c_real_q <= 1'b0;
      cnt_q    <= '0;
      q_q      <= '0;
      valid_q  <= 1'b0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
      skip_q   <= 1'b0;
      err_q    <= 1'b0;
      wcnt_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      fill_q   <= fill_d;
      c_q      <= c_d;
      c_real_q <= c_real_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      valid_q  <= valid_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
      skip_q   <= skip_d;
      err_q    <= err_d;
      wcnt_q   <= wcnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign Q       = q_q;
  assign Valid   = valid_q;
  assign Phase   = valid_q ? (8'd1 << q_q) : 8'd0;
  assign Step    = step_q;
  assign Wrap    = wrap_q;
  assign Skip    = skip_q;
  assign Err     = err_q;
  assign WrapCnt = wcnt_q;
  assign Ovf     = ovf_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Testbench for ripple_count_monitor. Two instances share the stimulus:
// dut0 with default parameters, dut1 with SYNC_STAGES=3, STABLE_SAMPLES=1,
// WRAP_W=2. A sliding-window reference model predicts every output of both
// instances each cycle. Directed literal checks pin the model.
module tb_ripple_count_monitor;

  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_rst = 1'b0;
  logic [2:0] t_drv = 3'd0;
  logic       clr   = 1'b0;

  logic [2:0] q0, q1;
  logic       valid0, valid1, step0, step1, wrap0, wrap1, skip0, skip1;
  logic       err0, err1, ovf0, ovf1;
  logic [7:0] phase0, phase1;
  logic [7:0] wcnt0;
  logic [1:0] wcnt1;

  ripple_count_monitor #(.SYNC_STAGES(2), .STABLE_SAMPLES(2), .WRAP_W(8)) dut0 (
    .Clk(clk), .nRst(n_rst), .T0(t_drv[0]), .T1(t_drv[1]), .T2(t_drv[2]), .Clr(clr),
    .Q(q0), .Valid(valid0), .Phase(phase0), .Step(step0), .Wrap(wrap0), .Skip(skip0),
    .Err(err0), .WrapCnt(wcnt0), .Ovf(ovf0)
  );

  ripple_count_monitor #(.SYNC_STAGES(3), .STABLE_SAMPLES(1), .WRAP_W(2)) dut1 (
    .Clk(clk), .nRst(n_rst), .T0(t_drv[0]), .T1(t_drv[1]), .T2(t_drv[2]), .Clr(clr),
    .Q(q1), .Valid(valid1), .Phase(phase1), .Step(step1), .Wrap(wrap1), .Skip(skip1),
    .Err(err1), .WrapCnt(wcnt1), .Ovf(ovf1)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;

  // Reference model: the value seen by the filter at an edge is the input
  // sampled SYNC_STAGES edges earlier; it is accepted once the last
  // STABLE_SAMPLES+1 such values (all sampled since reset) are identical.
  int ss_p [NI] = '{2, 3};
  int st_p [NI] = '{2, 1};
  int ww_p [NI] = '{8, 2};

  logic [2:0] hq[$];
  int m_q[NI], m_valid[NI], m_step[NI], m_wrap[NI], m_skip[NI];
  int m_err[NI], m_ovf[NI], m_wcnt[NI];

  initial begin : model
    forever begin
      @(posedge clk);
      if (!n_rst) begin
        hq.delete();
        for (int i = 0; i < NI; i++) begin
          m_q[i] = 0; m_valid[i] = 0; m_step[i] = 0; m_wrap[i] = 0;
          m_skip[i] = 0; m_err[i] = 0; m_ovf[i] = 0; m_wcnt[i] = 0;
        end
      end else begin
        hq.push_front(t_drv);
        if (hq.size() > 16) void'(hq.pop_back());
        for (int i = 0; i < NI; i++) begin
          int lo, hi, v, wmax;
          bit stable, acc;
          m_step[i] = 0; m_wrap[i] = 0; m_skip[i] = 0;
          lo = ss_p[i];
          hi = ss_p[i] + st_p[i];
          wmax = (1 << ww_p[i]) - 1;
          acc = 0;
          v = 0;
          if (hq.size() > hi) begin
            stable = 1;
            for (int d = lo + 1; d <= hi; d++)
              if (hq[d] != hq[lo]) stable = 0;
            v = int'(hq[lo]);
            if (stable && (m_valid[i] == 0 || v != m_q[i])) acc = 1;
          end
          if (acc) begin
            if (m_valid[i] != 0) begin
              if (v == (m_q[i] + 1) % 8) begin
                m_step[i] = 1;
                if (m_q[i] == 7) begin
                  m_wrap[i] = 1;
                  if (m_wcnt[i] == wmax) begin
                    m_wcnt[i] = 0;
                    m_ovf[i] = 1;
                  end else begin
                    m_wcnt[i] = m_wcnt[i] + 1;
                  end
                end
              end else begin
                m_skip[i] = 1;
                m_err[i] = 1;
              end
            end
            m_q[i] = v;
            m_valid[i] = 1;
          end
          if (clr) begin
            m_wcnt[i] = 0; m_err[i] = 0; m_ovf[i] = 0;
          end
        end
      end
    end
  end

  function automatic logic [24:0] pack_obs(logic [2:0] q, logic v, logic [7:0] ph,
                                           logic st, logic wr, logic sk, logic er,
                                           logic ov, logic [7:0] wc);
    return {q, v, ph, st, wr, sk, er, ov, wc};
  endfunction

  // Pulse tallies for dut0, cleared by the stimulus between directed tests.
  int n_step0 = 0, n_wrap0 = 0, n_skip0 = 0;

  initial begin : compare
    logic [24:0] got, exp_v;
    logic [7:0]  exp_ph;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      n_step0 += int'(step0);
      n_wrap0 += int'(wrap0);
      n_skip0 += int'(skip0);
      for (int i = 0; i < NI; i++) begin
        exp_ph = (m_valid[i] != 0) ? (8'd1 << m_q[i]) : 8'd0;
        exp_v  = pack_obs(3'(m_q[i]), m_valid[i] != 0, exp_ph, m_step[i] != 0,
                          m_wrap[i] != 0, m_skip[i] != 0, m_err[i] != 0,
                          m_ovf[i] != 0, 8'(m_wcnt[i]));
        if (i == 0) got = pack_obs(q0, valid0, phase0, step0, wrap0, skip0, err0, ovf0, wcnt0);
        else        got = pack_obs(q1, valid1, phase1, step1, wrap1, skip1, err1, ovf1, {6'd0, wcnt1});
        n_checks++;
        if (got !== exp_v) begin
          n_errors++;
          $display("FAIL model_cmp dut%0d cycle %0d: got {q,v,ph,st,wr,sk,er,ov,wc}=%h required %h",
                   i, cycle, got, exp_v);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int expv);
    n_checks++;
    if (got != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d", name, got, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold(input logic [2:0] v, input int n);
    t_drv = v;
    tick(n);
  endtask

  task automatic clr_tally();
    n_step0 = 0; n_wrap0 = 0; n_skip0 = 0;
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [2:0] cur;
    tick(3);
    chk("reset_q", int'(q0), 0);
    chk("reset_valid", int'(valid0), 0);
    chk("reset_phase", int'(phase0), 0);
    chk("reset_wrapcnt", int'(wcnt0), 0);

    // Test 1: release with T=0; Valid rises on the fifth edge.
    n_rst = 1'b1;
    t_drv = 3'd0;
    repeat (4) @(posedge clk);
    #1;
    chk("t1_valid_edge4", int'(valid0), 0);
    @(posedge clk);
    #1;
    chk("t1_valid_edge5", int'(valid0), 1);
    chk("t1_valid1_edge5", int'(valid1), 1);
    chk("t1_q", int'(q0), 0);
    chk("t1_phase", int'(phase0), 8'h01);
    chk("t1_step", int'(step0), 0);
    chk("t1_skip", int'(skip0), 0);
    @(negedge clk);

    // Test 2: full count cycle 0..7,0.
    tick(5);
    clr_tally();
    for (int v = 1; v <= 8; v++) hold(3'(v % 8), 10);
    chk("t2_steps", n_step0, 8);
    chk("t2_wraps", n_wrap0, 1);
    chk("t2_wrapcnt", int'(wcnt0), 1);
    chk("t2_wrapcnt1", int'(wcnt1), 1);
    chk("t2_err", int'(err0), 0);
    chk("t2_phase", int'(phase0), 8'h01);

    // Test 3: ripple glitch 3 -> 010 (2 cycles) -> 4.
    hold(3'd1, 10); hold(3'd2, 10); hold(3'd3, 10);
    clr_tally();
    hold(3'b010, 2);
    hold(3'b100, 10);
    chk("t3_q", int'(q0), 4);
    chk("t3_steps", n_step0, 1);
    chk("t3_skips", n_skip0, 0);
    chk("t3_phase", int'(phase0), 8'h10);

    // Test 4: illegal jump 2 -> 5, then Clr.
    for (int v = 5; v <= 10; v++) hold(3'(v % 8), 10);
    clr_pulse();
    tick(2);
    clr_tally();
    hold(3'd5, 10);
    chk("t4_q", int'(q0), 5);
    chk("t4_err", int'(err0), 1);
    chk("t4_skips", n_skip0, 1);
    chk("t4_steps", n_step0, 0);
    clr_pulse();
    tick(1);
    chk("t4_err_cleared", int'(err0), 0);
    chk("t4_q_kept", int'(q0), 5);

    // Test 5: wrap counter rollover on dut1 (WRAP_W=2).
    clr_pulse();
    tick(2);
    cur = 3'd5;
    for (int w = 0; w < 4; w++) begin
      do begin
        cur = cur + 3'd1;
        hold(cur, 10);
      end while (cur != 3'd0);
      chk($sformatf("t5_wrapcnt1_w%0d", w), int'(wcnt1), (w + 1) % 4);
      chk($sformatf("t5_ovf1_w%0d", w), int'(ovf1), (w == 3) ? 1 : 0);
    end
    chk("t5_wrapcnt0", int'(wcnt0), 4);
    for (int v = 1; v <= 7; v++) hold(3'(v), 10);
    t_drv = 3'd0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_clr_wrap1", int'(wrap1), 1);
    chk("t5_clr_wrapcnt1", int'(wcnt1), 0);
    chk("t5_clr_ovf1", int'(ovf1), 0);
    chk("t5_clr_wrap0", int'(wrap0), 1);
    chk("t5_clr_wrapcnt0", int'(wcnt0), 0);
    @(negedge clk);
    clr = 1'b0;
    tick(5);

    // Test 6: reset mid-count at Q=6, release with T=2.
    for (int v = 1; v <= 6; v++) hold(3'(v), 10);
    chk("t6_q_before", int'(q0), 6);
    n_rst = 1'b0;
    #1;
    chk("t6_rst_q", int'(q0), 0);
    chk("t6_rst_valid", int'(valid0), 0);
    chk("t6_rst_phase", int'(phase0), 0);
    t_drv = 3'd2;
    tick(3);
    n_rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_q", int'(q0), 2);
    chk("t6_valid", int'(valid0), 1);
    chk("t6_skip", int'(skip0), 0);
    chk("t6_err", int'(err0), 0);
    @(negedge clk);

    // Randomized phase: mostly +1 steps, some jumps, glitches, Clr and resets.
    cur = t_drv;
    for (int it = 0; it < 2500; it++) begin
      if ($urandom_range(0, 1) == 0) cur = cur + 3'd1;
      else                           cur = 3'($urandom_range(0, 7));
      t_drv = cur;
      if ($urandom_range(0, 19) == 0) clr = 1'b1;
      if ($urandom_range(0, 199) == 0) n_rst = 1'b0;
      tick(1);
      clr = 1'b0;
      n_rst = 1'b1;
      tick($urandom_range(0, 6));
    end
    tick(10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
